// File: rtl/xalu.sv
// xalu: HI/LO multiply/divide unit with fixed-latency MULT/MULTU (5 cycles) and
// DIV/DIVU (10 cycles, only when XALU_DIV_EN is defined), plus MTHI/MTLO writes.
module xalu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] xaluout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    // Initializers give the same power-up state as reset.
    logic [0:0]  state_q = ST_IDLE;
    logic [0:0]  state_d;
    logic [3:0]  cnt_q = 4'd0;
    logic [3:0]  cnt_d;
    logic [2:0]  op_q = 3'd0;
    logic [2:0]  op_d;
    logic [31:0] a_q = 32'd0;
    logic [31:0] a_d;
    logic [31:0] b_q = 32'd0;
    logic [31:0] b_d;
    logic [31:0] hi_q = 32'd0;
    logic [31:0] hi_d;
    logic [31:0] lo_q = 32'd0;
    logic [31:0] lo_d;

    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] mul_prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_valid;

`ifdef XALU_DIV_EN
    logic        div_sel;
    logic        div_neg_a;
    logic        div_neg_b;
    logic [31:0] div_mag_a;
    logic [31:0] div_mag_b;
    logic [31:0] div_uq;
    logic [31:0] div_ur;
    logic [31:0] div_q;
    logic [31:0] div_r;
`endif

    always_comb begin
        mul_ext_a = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mul_ext_b = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        mul_prod  = mul_ext_a * mul_ext_b;
    end

`ifdef XALU_DIV_EN
    // Signed division is done on magnitudes; 0x80000000 / -1 falls out as 0x80000000.
    always_comb begin
        div_sel   = (op_q == OP_DIV) || (op_q == OP_DIVU);
        div_neg_a = (op_q == OP_DIV) && a_q[31];
        div_neg_b = (op_q == OP_DIV) && b_q[31];
        div_mag_a = div_neg_a ? (32'd0 - a_q) : a_q;
        div_mag_b = div_neg_b ? (32'd0 - b_q) : b_q;
        if (b_q == 32'd0) begin
            div_uq = 32'd0;
            div_ur = 32'd0;
        end else begin
            div_uq = div_mag_a / div_mag_b;
            div_ur = div_mag_a % div_mag_b;
        end
        div_q = (div_neg_a ^ div_neg_b) ? (32'd0 - div_uq) : div_uq;
        div_r = div_neg_a ? (32'd0 - div_ur) : div_ur;
    end

    always_comb begin
        if (div_sel) begin
            res_hi    = div_r;
            res_lo    = div_q;
            res_valid = (b_q != 32'd0);
        end else begin
            res_hi    = mul_prod[63:32];
            res_lo    = mul_prod[31:0];
            res_valid = 1'b1;
        end
    end
`else
    always_comb begin
        res_hi    = mul_prod[63:32];
        res_lo    = mul_prod[31:0];
        res_valid = 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        state_d = ST_BUSY;
                        cnt_d   = MUL_CYCLES;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end
`ifdef XALU_DIV_EN
                    OP_DIV, OP_DIVU: begin
                        state_d = ST_BUSY;
                        cnt_d   = DIV_CYCLES;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end
`endif
                    OP_MTHI: hi_d = a;
                    OP_MTLO: lo_d = a;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = ST_IDLE;
                if (res_valid) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = (state_q == ST_BUSY);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign xaluout = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_xalu.sv
// tb_xalu: table vectors, hand-written reset/ignore sequences and randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_xalu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] xaluout;

    int n_compared = 0;
    int n_mismatched = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    xalu dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_sel(rd_sel), .busy(busy), .hi(hi), .lo(lo), .xaluout(xaluout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: what HI/LO must hold after the op, and how long busy stays high.
    function automatic void refModel(input logic [2:0] f_op, input logic [31:0] fa, input logic [31:0] fb,
                                     input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                     output logic [31:0] eh, output logic [31:0] el, output int ec);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              iq, ir;
        eh = cur_hi;
        el = cur_lo;
        ec = 0;
        sa = $signed(fa);
        sb = $signed(fb);
        ua = {32'd0, fa};
        ub = {32'd0, fb};
        case (f_op)
            3'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; ec = 5; end
            3'd1: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; ec = 5; end
`ifdef XALU_DIV_EN
            3'd2: begin
                ec = 10;
                if (fb != 0) begin
                    if (fa == 32'h80000000 && fb == 32'hFFFFFFFF) begin
                        el = 32'h80000000; eh = 32'd0;
                    end else begin
                        iq = int'(fa) / int'(fb);
                        ir = int'(fa) % int'(fb);
                        el = iq; eh = ir;
                    end
                end
            end
            3'd3: begin
                ec = 10;
                if (fb != 0) begin el = fa / fb; eh = fa % fb; end
            end
`endif
            3'd4: eh = fa;
            3'd5: el = fa;
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] s_op, input logic [31:0] sa, input logic [31:0] sb);
        @(negedge clk);
        op = s_op; a = sa; b = sb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // One op end-to-end; while busy, inputs and start are scrambled and must be ignored.
    task automatic runOp(input string name, input logic [2:0] r_op, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [31:0] eh, input logic [31:0] el, input int ec);
        int cycles;
        logic first;
        cycles = 0;
        first  = 1'b1;
        applyStimulus(r_op, ra, rb);
        while (busy && cycles < 40) begin
            if (first) begin
                checkOutput({name, " hold hi"}, hi, m_hi);
                checkOutput({name, " hold lo"}, lo, m_lo);
                first = 1'b0;
            end
            cycles++;
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({name, " busy cycles"}, 32'(cycles), 32'(ec));
        checkOutput({name, " hi"}, hi, eh);
        checkOutput({name, " lo"}, lo, el);
        rd_sel = 1'b0; #1;
        checkOutput({name, " xaluout hi"}, xaluout, eh);
        rd_sel = 1'b1; #1;
        checkOutput({name, " xaluout lo"}, xaluout, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] eh, el;
        int ec, waits;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset xaluout", xaluout, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        vecs.push_back('{"MULT -2*3",   3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        vecs.push_back('{"op6 ignored", 3'd6, 32'h00001234, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFA, 0});
        vecs.push_back('{"MULTU max",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
        vecs.push_back('{"MTHI",        3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0});
        vecs.push_back('{"MTLO",        3'd5, 32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0});
        vecs.push_back('{"op7 ignored", 3'd7, 32'h0BADF00D, 32'd9,        32'h12345678, 32'hCAFEBABE, 0});
`ifdef XALU_DIV_EN
        vecs.push_back('{"DIV -7/2",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{"DIVU 7/0",    3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{"DIV ovf",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
        vecs.push_back('{"DIVU 100/7",  3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10});
`else
        vecs.push_back('{"DIV off",     3'd2, 32'hFFFFFFF9, 32'd2,        32'h12345678, 32'hCAFEBABE, 0});
        vecs.push_back('{"DIVU off",    3'd3, 32'd100,      32'd7,        32'h12345678, 32'hCAFEBABE, 0});
`endif
        foreach (vecs[i])
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);

        // MTHI issued while a multiply is in flight must be dropped.
        applyStimulus(3'd0, 32'd2, 32'd3);
        op = 3'd4; a = 32'h12345678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waits = 0;
        while (busy && waits < 20) begin waits++; @(negedge clk); end
        checkOutput("MTHI in busy: done", {31'd0, busy}, 32'd0);
        checkOutput("MTHI in busy: hi", hi, 32'd0);
        checkOutput("MTHI in busy: lo", lo, 32'd6);
        m_hi = 32'd0; m_lo = 32'd6;

        // Mid-operation reset aborts with no later write.
        runOp("MTLO pre-reset", 3'd5, 32'h00000055, 32'd0, 32'd0, 32'h00000055, 0);
        applyStimulus(3'd0, 32'd7, 32'd9);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("abort later busy", {31'd0, busy}, 32'd0);
        checkOutput("abort later lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checkOutput("reset vs MTHI hi", hi, 32'd0);
        reset = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checkOutput("reset vs MULT busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("reset vs MULT lo", lo, 32'd0);

        for (int k = 0; k < 80; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            refModel(rop, ra, rb, m_hi, m_lo, eh, el, ec);
            runOp($sformatf("rand%0d op%0d", k, rop), rop, ra, rb, eh, el, ec);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/xalu.md
XALU -- requirements
Module: xalu

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL: start  input  1  request strobe; starts the operation selected by op, sampled each edge.
REQ-004 SHALL: op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
REQ-005 SHALL: a  input  32  operand A (dividend, multiplicand, or MTHI/MTLO source).
REQ-006 SHALL: b  input  32  operand B (divisor, multiplier).
REQ-007 SHALL: rd_sel  input  1  read select: 0 HI, 1 LO.
REQ-008 SHALL: busy  output  1  operation in flight; the hazard unit stalls on start|busy.
REQ-009 SHALL: hi  output  32  HI register.
REQ-010 SHALL: lo  output  32  LO register.
REQ-011 SHALL: xaluout  output  32  combinational rd_sel ? lo : hi; feeds the EX/MEM XALUOUT path into MEM/WB.

Function
REQ-012 SHALL: use two states, IDLE (busy=0) and BUSY (busy=1), plus a 4-bit down-counter cnt.
REQ-013 SHALL: in IDLE with start=1 and op in 0..3, latch a, b and op on that edge, enter BUSY, and load cnt with N (MULT/MULTU N=5, DIV/DIVU N=10).
REQ-014 SHALL: in BUSY, decrement cnt on each edge; on the edge where cnt==1, write hi/lo with the result and return to IDLE.
REQ-015 SHALL: keep busy high for exactly N cycles after the start edge, with hi/lo changing on the same edge busy falls.
REQ-016 SHALL: for MULT/MULTU, form the 64-bit signed/unsigned product of the latched operands; hi=[63:32], lo=[31:0].
REQ-017 SHALL: for DIV/DIVU, set lo=quotient and hi=remainder; signed quotient truncates toward zero and signed remainder takes the sign of the dividend.
REQ-018 SHALL: for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-019 SHALL: for a divisor of 0, still run N cycles and leave hi/lo unchanged.
REQ-020 SHALL: in IDLE with start=1, write hi (op 4) or lo (op 5) from a on that edge, without entering BUSY.
REQ-021 SHALL: ignore start in BUSY (including MTHI/MTLO), with no effect on operands, cnt or hi/lo.
REQ-022 SHALL: ignore reserved op values 6/7.
REQ-023 SHALL: hold hi/lo at their prior values while in BUSY, so xaluout shows pre-operation values until completion.
REQ-024 SHALL: not consume a new operand change on a/b while in BUSY.

Reset
REQ-025 SHALL: on an edge with reset=1, set state=IDLE, cnt=0, busy=0, hi=0, lo=0 and clear the latched operands.
REQ-026 SHALL: abort any in-flight operation on mid-operation reset, with no hi/lo write.
REQ-027 SHALL: give reset priority over start on the same edge.
REQ-028 SHALL: power up (initial) with the same values as reset.

Configuration
REQ-029 SHALL: with XALU_DIV_EN defined, implement DIV/DIVU as specified.
REQ-030 SHALL: with XALU_DIV_EN undefined, omit divider logic and treat op 2/3 as reserved (ignored, busy stays 0); MULT/MULTU/MTHI/MTLO are unaffected.

Verification
REQ-031 SHALL: MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 SHALL: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL: DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-034 SHALL: MTHI a=0x12345678 while IDLE -> hi=0x12345678 next edge, xaluout=0x12345678 with rd_sel=0; the same MTHI issued during BUSY -> ignored.
REQ-035 SHALL: MULT started, then reset asserted at cycle 3 of BUSY -> busy=0, hi=lo=0, and no later write occurs.
REQ-036 SHALL: with XALU_DIV_EN undefined, DIV start -> busy stays 0 and hi/lo unchanged.
